// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLK_DIV_9600 = 5208;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side push strobe and status bundle of the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_en;
    logic [7:0]                    wr_data;
    logic                          ovf_clr;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          overflow;
    logic                          busy;
    logic                          tx_done;

    modport master (
        output wr_en, wr_data, ovf_clr,
        input  full, empty, level, overflow, busy, tx_done
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output full, empty, level, overflow, busy, tx_done
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO; pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    always_ff @(posedge sysclk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Occupancy is kept apart from the pointers so a full FIFO is distinguishable from an empty one.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;
endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 LSB-first UART transmitter fed by a byte FIFO, streaming frames back to back.
//  state | meaning
//  IDLE  | line high, waiting for a byte in the FIFO
//  START | start bit (low) for CLK_DIV cycles
//  DATA  | eight data bits, LSB first
//  STOP  | stop bit (high); chains straight into START when more data waits
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV_9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    uart_tx_fifo_if.slave     bus,
    output logic              o_uart_tx
);
    localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int          IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [15:0] BAUD_TC  = 16'(CLK_DIV - 1);
    localparam logic [15:0] DONE_CNT = 16'(CLK_DIV - 2);

    uart_tx_state_t            r_state;
    logic [15:0]               r_baud;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_tx_done;
    logic                      r_overflow;

    logic                      w_full;
    logic                      w_empty;
    logic [LVL_W-1:0]          w_level;
    logic [UART_DATA_BITS-1:0] w_rd_data;
    logic                      w_pop;
    logic                      w_baud_tc;

    assign w_baud_tc = (r_baud == BAUD_TC);
    assign w_pop     = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_baud_tc));

    uart_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .i_push  (bus.wr_en),
        .i_data  (bus.wr_data),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            // Raised one cycle early so the pulse lands on the last stop-bit cycle.
            r_tx_done <= (r_state == STOP) && (r_baud == DONE_CNT);
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= w_rd_data;
                        r_state <= START;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_baud_tc) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        r_baud    <= '0;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                DATA: begin
                    if (w_baud_tc) begin
                        r_baud <= '0;
                        if (r_bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                STOP: begin
                    if (w_baud_tc) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_rd_data;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A dropped write in the same cycle as a clear keeps the flag set.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (bus.wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_uart_tx    = r_tx;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = w_level;
    assign bus.overflow = r_overflow;
    assign bus.busy     = r_busy;
    assign bus.tx_done  = r_tx_done;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=4 and a 16-entry FIFO.
module tb_uart_tx_fifo;
    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    logic uart_tx;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_b [0:31];

    uart_tx_fifo_if #(.FIFO_DEPTH(16)) bus ();

    uart_tx_fifo #(
        .CLK_DIV    (4),
        .FIFO_DEPTH (16)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .bus       (bus.slave),
        .o_uart_tx (uart_tx)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // k counts edges after the push edge N; frame f bit b spans k = 40f+4b+1 .. 40f+4b+4.
    task automatic watch(input int k0, input int nf, input string tag);
        int bad_tx   = 0;
        int bad_done = 0;
        int bad_busy = 0;
        logic [9:0] frame;
        for (int k = k0; k <= 40 * nf; k++) begin
            tick();
            frame = {1'b1, exp_b[(k - 1) / 40], 1'b0};
            if (uart_tx !== frame[((k - 1) % 40) / 4]) bad_tx++;
            if (bus.tx_done !== ((k % 40) == 0)) bad_done++;
            if (bus.busy !== 1'b1) bad_busy++;
        end
        chk({tag, "_tx_bits"}, bad_tx, 0);
        chk({tag, "_tx_done"}, bad_done, 0);
        chk({tag, "_busy_hi"}, bad_busy, 0);
        tick();
        chk({tag, "_busy_end"}, bus.busy, 1'b0);
        chk({tag, "_idle_line"}, uart_tx, 1'b1);
        chk({tag, "_empty_end"}, bus.empty, 1'b1);
    endtask

    initial begin
        int bad;
        bit drained;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_level", bus.level, 0);
        chk("rst_done", bus.tx_done, 1'b0);
        chk("rst_ovf", bus.overflow, 1'b0);
        reset = 1'b1;
        tick();

        // Single byte 0x55
        push(8'h55);
        chk("single_lvl_n", bus.level, 1);
        chk("single_tx_n", uart_tx, 1'b1);
        tick();
        chk("single_fall_n1", uart_tx, 1'b0);
        chk("single_busy_n1", bus.busy, 1'b1);
        chk("single_lvl_n1", bus.level, 0);
        exp_b[0] = 8'h55;
        watch(2, 1, "single");

        // Streaming three frames
        push(8'hA3);
        chk("strm_lvl_k0", bus.level, 1);
        push(8'h00);
        chk("strm_lvl_k1", bus.level, 1);
        push(8'hFF);
        chk("strm_lvl_k2", bus.level, 2);
        exp_b[0] = 8'hA3;
        exp_b[1] = 8'h00;
        exp_b[2] = 8'hFF;
        watch(3, 3, "strm");

        // Overflow while a frame is running
        push(8'h11);
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
        chk("ovf_level", bus.level, 16);
        chk("ovf_full", bus.full, 1'b1);
        chk("ovf_flag", bus.overflow, 1'b1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", bus.overflow, 1'b0);
        exp_b[0] = 8'h11;
        for (int i = 0; i < 16; i++) exp_b[i + 1] = 8'h80 + 8'(i);
        watch(19, 17, "ovf");

        // Push and pop on the same edge at level 15
        push(8'h01);
        for (int i = 1; i <= 15; i++) push(8'h40 + 8'(i));
        chk("simul_lvl_pre", bus.level, 15);
        for (int k = 16; k <= 40; k++) tick();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h50;
        tick();
        bus.wr_en   = 1'b0;
        chk("simul_level", bus.level, 15);
        chk("simul_full", bus.full, 1'b0);
        chk("simul_ovf", bus.overflow, 1'b0);
        chk("simul_restart", uart_tx, 1'b0);
        drained = 1'b0;
        for (int i = 0; i < 800 && !drained; i++) begin
            tick();
            if (!bus.busy && bus.empty) drained = 1'b1;
        end
        chk("simul_drain", drained, 1'b1);

        // Reset during DATA bit 3 of 0x0F
        tick();
        push(8'h0F);
        push(8'h22);
        push(8'h33);
        chk("rmid_lvl", bus.level, 2);
        for (int k = 3; k <= 18; k++) tick();
        #2 reset = 1'b0;
        #1;
        chk("rmid_tx", uart_tx, 1'b1);
        chk("rmid_level", bus.level, 0);
        chk("rmid_busy", bus.busy, 1'b0);
        chk("rmid_done", bus.tx_done, 1'b0);
        tick();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_tx !== 1'b1 || bus.tx_done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("rmid_quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
